// File: rtl/mdu_seq.sv
// Sequential RISC-V M-extension unit: multiplies resolve in one compute cycle,
// divides run a radix-2 restoring loop; results are tagged with the issuing thread.
`timescale 1ns/1ps
module mdu_seq #(
    parameter int XLEN  = 32,
    parameter int TID_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TID_W-1:0] tid,
    input  logic             flush_valid,
    input  logic [TID_W-1:0] flush_tid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TID_W-1:0] out_tid,
    output logic             busy
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [TID_W-1:0]  tid_q, tid_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]     count_q, count_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [TID_W-1:0]  out_tid_q, out_tid_d;

    logic              accept;
    logic              flush_hit;
    logic              signed_div;
    logic              b_zero;
    logic              ovf;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN-1:0] mul_a_w;
    logic [2*XLEN-1:0] mul_b_w;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_sub;
    logic              ge;
    logic [XLEN-1:0]   rem_nx;
    logic [XLEN-1:0]   quo_nx;
    logic [XLEN-1:0]   div_res;

    assign in_ready  = (state_q == IDLE) && !reset;
    assign accept    = in_valid && in_ready;
    assign flush_hit = flush_valid && (flush_tid == tid_q) && (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    // A flush that lands in DONE retracts the result so no handshake can happen.
    assign out_valid = (state_q == DONE) && !flush_hit;
    assign result    = result_q;
    assign out_tid   = out_tid_q;

    // Accept-time decode of divide specials and operand magnitudes.
    assign signed_div = !op[0];
    assign b_zero     = (b == '0);
    assign ovf        = signed_div && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign a_mag      = (signed_div && a[XLEN-1]) ? -a : a;
    assign b_mag      = (signed_div && b[XLEN-1]) ? -b : b;

    // Sign-extend to 2*XLEN so a plain truncated product covers all four variants.
    assign mul_a_w = {{XLEN{(op_q == 3'd1 || op_q == 3'd2) && a_q[XLEN-1]}}, a_q};
    assign mul_b_w = {{XLEN{(op_q == 3'd1) && b_q[XLEN-1]}}, b_q};
    assign prod    = mul_a_w * mul_b_w;
    assign mul_res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // One restoring step: the partial remainder is always below 2*divisor.
    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign rem_sub = rem_sh - {1'b0, dvs_q};
    assign ge      = !rem_sub[XLEN];
    assign rem_nx  = ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nx  = {quo_q[XLEN-2:0], ge};
    assign div_res = op_q[1] ? (negr_q ? -rem_nx : rem_nx)
                             : (negq_q ? -quo_nx : quo_nx);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tid_d     = tid_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        count_d   = count_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        result_d  = result_q;
        out_tid_d = out_tid_q;
        if (flush_hit) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_d  = op;
                        tid_d = tid;
                        a_d   = a;
                        b_d   = b;
                        if (!op[2]) begin
                            state_d = MUL;
                        end else if (b_zero) begin
                            state_d   = DONE;
                            result_d  = op[1] ? a : '1;
                            out_tid_d = tid;
                        end else if (ovf) begin
                            state_d   = DONE;
                            result_d  = op[1] ? '0 : a;
                            out_tid_d = tid;
                        end else begin
                            state_d = DIV;
                            rem_d   = '0;
                            quo_d   = a_mag;
                            dvs_d   = b_mag;
                            count_d = CW'(XLEN);
                            negq_d  = signed_div && (a[XLEN-1] ^ b[XLEN-1]);
                            negr_d  = signed_div && a[XLEN-1];
                        end
                    end
                end
                MUL: begin
                    state_d   = DONE;
                    result_d  = mul_res;
                    out_tid_d = tid_q;
                end
                DIV: begin
                    rem_d   = rem_nx;
                    quo_d   = quo_nx;
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d   = DONE;
                        result_d  = div_res;
                        out_tid_d = tid_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            tid_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            count_q   <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            result_q  <= '0;
            out_tid_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tid_q     <= tid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            count_q   <= count_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            result_q  <= result_d;
            out_tid_q <= out_tid_d;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vector table, randomized ops against
// an arithmetic reference model, and hand-written handshake/flush/reset sequences.
`timescale 1ns/1ps
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  tid;
    logic        flush_valid;
    logic [1:0]  flush_tid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [1:0]  out_tid;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    mdu_seq #(.XLEN(32), .TID_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .tid         (tid),
        .flush_valid (flush_valid),
        .flush_tid   (flush_tid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .out_tid     (out_tid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  tid;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic with the RISC-V special cases.
    function automatic logic [31:0] model(input logic [2:0] m_op, input logic [31:0] m_a,
                                          input logic [31:0] m_b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          p;
        longint unsigned up;
        logic            ovf;
        sa  = {{32{m_a[31]}}, m_a};
        sb  = {{32{m_b[31]}}, m_b};
        ua  = {32'd0, m_a};
        ub  = {32'd0, m_b};
        ovf = (m_a == 32'h8000_0000) && (m_b == 32'hFFFF_FFFF);
        p   = 0;
        up  = 0;
        case (m_op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (m_b == 0) return 32'hFFFF_FFFF;
                if (ovf) return m_a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (m_b == 0) return 32'hFFFF_FFFF;
                up = ua / ub;
                return up[31:0];
            end
            3'd6: begin
                if (m_b == 0) return m_a;
                if (ovf) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (m_b == 0) return m_a;
                up = ua % ub;
                return up[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] m_op, input logic [31:0] m_a,
                                     input logic [31:0] m_b);
        if (m_op < 3'd4) return 2;
        if (m_b == 0) return 1;
        if (!m_op[0] && m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic issue(input logic [2:0] i_op, input logic [31:0] i_a, input logic [31:0] i_b,
                         input logic [1:0] i_tid);
        op       = i_op;
        a        = i_a;
        b        = i_b;
        tid      = i_tid;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] r_op, input logic [31:0] r_a,
                          input logic [31:0] r_b, input logic [1:0] r_tid,
                          input logic [31:0] r_exp, input int r_lat);
        int lat;
        chk({name, ".in_ready"}, in_ready, 1);
        issue(r_op, r_a, r_b, r_tid);
        wait_valid(lat);
        $display("txn %s op=%0d a=%h b=%h tid=%0d result=%h out_tid=%0d lat=%0d",
                 name, r_op, r_a, r_b, r_tid, result, out_tid, lat);
        chk({name, ".latency"}, lat, r_lat);
        chk({name, ".result"}, result, r_exp);
        chk({name, ".out_tid"}, out_tid, r_tid);
        handshake();
        chk({name, ".out_valid_drop"}, out_valid, 0);
    endtask

    logic [31:0] hold_res;
    logic [1:0]  hold_tid;
    logic        seen;
    int          lat_g;

    initial begin
        vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'd2, 2'd1, 32'hFFFF_FFFE, 2};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2, 2'd2, 32'hFFFF_FFFF, 2};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'd2, 2'd3, 32'hFFFF_FFFF, 2};
        vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'd2, 2'd0, 32'h0000_0001, 2};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 2'd1, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 2'd2, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'hFFFF_FFF9, 32'd2, 2'd3, 32'h7FFF_FFFC, 33};
        vecs[7]  = '{3'd7, 32'hFFFF_FFF9, 32'd2, 2'd0, 32'h0000_0001, 33};
        vecs[8]  = '{3'd4, 32'd5, 32'd0, 2'd1, 32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5, 32'd0, 2'd2, 32'd5, 1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 2'd3, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 2'd1, 32'd0, 1};

        reset       = 1'b1;
        in_valid    = 1'b0;
        op          = '0;
        a           = '0;
        b           = '0;
        tid         = '0;
        flush_valid = 1'b0;
        flush_tid   = '0;
        out_ready   = 1'b0;
        tick();
        tick();
        chk("reset.out_valid", out_valid, 0);
        chk("reset.in_ready", in_ready, 0);
        chk("reset.busy", busy, 0);
        chk("reset.result", result, 0);
        chk("reset.out_tid", out_tid, 0);
        reset = 1'b0;
        #1;
        chk("release.in_ready", in_ready, 1);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tid,
                   vecs[i].exp, vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  r_op;
            logic [31:0] r_a;
            logic [31:0] r_b;
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 5))
                0: r_b = 32'd0;
                1: r_b = 32'($urandom_range(1, 15));
                2: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), r_op, r_a, r_b, 2'($urandom_range(0, 3)),
                   model(r_op, r_a, r_b), model_lat(r_op, r_a, r_b));
        end

        // Backpressure: DONE holds everything stable while out_ready is low.
        issue(3'd5, 32'd1000, 32'd7, 2'd2);
        wait_valid(lat_g);
        chk("bp.latency", lat_g, 33);
        hold_res = result;
        hold_tid = out_tid;
        chk("bp.result", hold_res, 32'd142);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp.out_valid", out_valid, 1);
            chk("bp.result_stable", result, hold_res);
            chk("bp.out_tid_stable", out_tid, hold_tid);
            chk("bp.in_ready", in_ready, 0);
        end
        handshake();
        chk("bp.in_ready_after", in_ready, 1);
        chk("bp.busy_after", busy, 0);
        $display("txn bp divu result=%h tid=%0d", hold_res, hold_tid);

        // Matching flush at cycle 10 of a divide.
        issue(3'd4, 32'd100, 32'd7, 2'd2);
        for (int i = 0; i < 9; i++) tick();
        flush_valid = 1'b1;
        flush_tid   = 2'd2;
        tick();
        flush_valid = 1'b0;
        chk("flush.busy", busy, 0);
        chk("flush.in_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= out_valid;
            tick();
        end
        chk("flush.no_result", seen, 0);
        $display("txn flush tid=2 div killed");

        // Flush of another thread leaves the divide alone.
        issue(3'd4, 32'd100, 32'd7, 2'd2);
        for (int i = 0; i < 9; i++) tick();
        flush_valid = 1'b1;
        flush_tid   = 2'd1;
        tick();
        flush_valid = 1'b0;
        lat_g = 11;
        while (out_valid !== 1'b1 && lat_g < 100) begin
            tick();
            lat_g++;
        end
        chk("nflush.latency", lat_g, 33);
        chk("nflush.result", result, 32'd14);
        chk("nflush.out_tid", out_tid, 2);
        handshake();
        $display("txn nflush div result=%h", result);

        // Flush in DONE beats a same-cycle out_ready.
        issue(3'd0, 32'd6, 32'd7, 2'd3);
        wait_valid(lat_g);
        chk("dflush.latency", lat_g, 2);
        out_ready   = 1'b1;
        flush_valid = 1'b1;
        flush_tid   = 2'd3;
        #1;
        chk("dflush.out_valid", out_valid, 0);
        tick();
        out_ready   = 1'b0;
        flush_valid = 1'b0;
        chk("dflush.busy", busy, 0);
        chk("dflush.in_ready", in_ready, 1);
        $display("txn dflush mul killed in DONE");

        // Reset in the middle of a divide.
        issue(3'd4, 32'd12345, 32'd3, 2'd1);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        #1;
        chk("mreset.out_valid", out_valid, 0);
        chk("mreset.busy", busy, 0);
        chk("mreset.in_ready", in_ready, 0);
        chk("mreset.result", result, 0);
        chk("mreset.out_tid", out_tid, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("mreset.in_ready_after", in_ready, 1);
        run_op("post_reset_mul", 3'd0, 32'd3, 32'd4, 2'd1, 32'd12, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
